// File: rtl/fetch_stage_pkg.sv
// Shared core constants for fetch, decode and instruction memory:
// word width, memory depth, bubble encoding and the fetch state type.
package fetch_stage_pkg;

   localparam int unsigned WORD_W          = 32;
   localparam int unsigned CORE_IMEM_DEPTH = 100;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t CORE_NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      FETCH_RUN  = 1'b0,
      FETCH_HALT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      word_t pc;
      word_t instr;
      logic  valid;
   } if_id_t;

   function automatic logic in_imem(input word_t addr, input int unsigned depth);
      return addr < word_t'(depth);
   endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program-counter register: synchronous reset to RESET_PC, loads only when enabled.
module pc_register
   import fetch_stage_pkg::*;
#(
   parameter word_t RESET_PC = '0
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  load_i,
   input  word_t pc_d_i,
   output word_t pc_q_o
);

   word_t pc_q;

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (load_i) begin
         pc_q <= pc_d_i;
      end
   end

   assign pc_q_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address,
// and fills the IF/ID register honouring freeze, branch redirect and halt.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = CORE_IMEM_DEPTH,
   parameter word_t       RESET_PC   = '0,
   parameter word_t       NOP_INSTR  = CORE_NOP_INSTR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branch_addr,
   output logic [WORD_W-1:0] imem_addr,
   input  logic [WORD_W-1:0] imem_instr,
   output logic [WORD_W-1:0] if_id_pc,
   output logic [WORD_W-1:0] if_id_instr,
   output logic              if_id_valid,
   output logic              halted,
   output logic [WORD_W-1:0] fetch_count
);

   localparam if_id_t BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

   // A reset PC outside the populated space starts the stage already halted.
   localparam fetch_state_e RESET_STATE =
      in_imem(RESET_PC, IMEM_DEPTH) ? FETCH_RUN : FETCH_HALT;

   word_t        pc_q;
   word_t        pc_d;
   word_t        pc_inc;
   logic         pc_load;
   fetch_state_e state_q;
   fetch_state_e state_d;
   if_id_t       if_id_q;
   if_id_t       if_id_d;
   word_t        count_q;
   word_t        count_d;

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk    (clk),
      .rst    (rst),
      .load_i (pc_load),
      .pc_d_i (pc_d),
      .pc_q_o (pc_q)
   );

   assign pc_inc = pc_q + word_t'(1);

   // NOTE: every signal gets a default before the priority chain so no path
   // leaves one unassigned, which would infer a latch.
   always_comb begin
      pc_d    = pc_q;
      pc_load = 1'b0;
      state_d = state_q;
      if_id_d = if_id_q;
      count_d = count_q;

      if (branch_taken) begin
         // Redirect wins over freeze and flushes the wrong-path fetch.
         pc_d    = branch_addr;
         pc_load = 1'b1;
         state_d = in_imem(branch_addr, IMEM_DEPTH) ? FETCH_RUN : FETCH_HALT;
         if_id_d = BUBBLE;
      end else if (!freeze) begin
         if (state_q == FETCH_RUN) begin
            pc_d    = pc_inc;
            pc_load = 1'b1;
            state_d = in_imem(pc_inc, IMEM_DEPTH) ? FETCH_RUN : FETCH_HALT;
            if_id_d = '{pc: pc_inc, instr: imem_instr, valid: 1'b1};
            count_d = count_q + word_t'(1);
         end else begin
            if_id_d = BUBBLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RESET_STATE;
         if_id_q <= BUBBLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if_id_q <= if_id_d;
         count_q <= count_d;
      end
   end

   assign halted      = (state_q == FETCH_HALT);
   // Parked at word 0 while halted so memory is never indexed out of range.
   assign imem_addr   = halted ? '0 : pc_q;
   assign if_id_pc    = if_id_q.pc;
   assign if_id_instr = if_id_q.instr;
   assign if_id_valid = if_id_q.valid;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model pushes expected
// post-edge outputs each cycle; they are popped and compared after the edge.
module tb_fetch_stage;

   localparam int unsigned DEPTH = 100;

   typedef struct {
      logic [31:0] if_pc;
      logic [31:0] if_instr;
      logic        if_valid;
      logic        halted;
      logic [31:0] count;
      logic [31:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        halted;
   logic [31:0] fetch_count;

   int checks = 0;
   int failures = 0;

   exp_t sb[$];

   logic [31:0] m_pc = '0;
   logic        m_halt = 1'b0;
   logic [31:0] m_if_pc = '0;
   logic [31:0] m_if_instr = '0;
   logic        m_if_valid = 1'b0;
   logic [31:0] m_count = '0;
   logic        m_init = 1'b0;

   fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_addr    (imem_addr),
      .imem_instr   (imem_instr),
      .if_id_pc     (if_id_pc),
      .if_id_instr  (if_id_instr),
      .if_id_valid  (if_id_valid),
      .halted       (halted),
      .fetch_count  (fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < DEPTH) return {8'hC0, a[7:0], a[15:0] ^ 16'h1234};
      return 32'hDEAD_BEEF;
   endfunction

   assign imem_instr = mem_word(imem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic f, input logic b, input logic [31:0] a);
      if (r) begin
         m_pc = '0; m_halt = 1'b0; m_count = '0;
         m_if_pc = '0; m_if_instr = '0; m_if_valid = 1'b0;
      end else if (b) begin
         m_pc = a; m_halt = (a >= DEPTH);
         m_if_pc = '0; m_if_instr = '0; m_if_valid = 1'b0;
      end else if (f) begin
         // everything holds
      end else if (!m_halt) begin
         m_if_instr = mem_word(m_pc);
         m_pc       = m_pc + 1;
         m_if_pc    = m_pc;
         m_if_valid = 1'b1;
         m_count    = m_count + 1;
         m_halt     = (m_pc >= DEPTH);
      end else begin
         m_if_pc = '0; m_if_instr = '0; m_if_valid = 1'b0;
      end
      m_init = 1'b1;
   endtask

   task automatic cycle(input logic r, input logic f, input logic b, input logic [31:0] a);
      exp_t e;
      @(negedge clk);
      rst = r; freeze = f; branch_taken = b; branch_addr = a;
      #1;
      if (m_init) check("imem_addr_pre", imem_addr, m_halt ? 32'd0 : m_pc);
      model_step(r, f, b, a);
      e.if_pc = m_if_pc; e.if_instr = m_if_instr; e.if_valid = m_if_valid;
      e.halted = m_halt; e.count = m_count; e.addr = m_halt ? 32'd0 : m_pc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("if_id_pc", if_id_pc, e.if_pc);
      check("if_id_instr", if_id_instr, e.if_instr);
      check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.if_valid});
      check("halted", {31'd0, halted}, {31'd0, e.halted});
      check("fetch_count", fetch_count, e.count);
      check("imem_addr", imem_addr, e.addr);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset, then free-run five fetches.
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      check("reset_if_valid", {31'd0, if_id_valid}, 32'd0);
      check("reset_count", fetch_count, 32'd0);
      run(5);
      check("run5_count", fetch_count, 32'd5);
      check("run5_if_pc", if_id_pc, 32'd5);

      // Freeze three cycles at pc=2, then resume.
      cycle(1'b1, 1'b0, 1'b0, '0);
      run(2);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0);
      check("freeze_addr", imem_addr, 32'd2);
      check("freeze_instr", if_id_instr, mem_word(32'd1));
      run(2);

      // Branch to 3 together with freeze: bubble, then target.
      cycle(1'b0, 1'b1, 1'b1, 32'd3);
      check("br_bubble_valid", {31'd0, if_id_valid}, 32'd0);
      run(1);
      check("br_target_instr", if_id_instr, mem_word(32'd3));
      check("br_target_pc", if_id_pc, 32'd4);
      run(2);

      // branch_addr ignored without branch_taken.
      cycle(1'b0, 1'b0, 1'b0, 32'd77);

      // Free-run off the end of memory.
      cycle(1'b1, 1'b0, 1'b0, '0);
      run(100);
      check("end_halted", {31'd0, halted}, 32'd1);
      check("end_count", fetch_count, 32'd100);
      check("end_last_instr", if_id_instr, mem_word(32'd99));
      run(3);

      // In HALT: out-of-range branch stays halted, in-range branch resumes.
      cycle(1'b0, 1'b0, 1'b1, 32'd150);
      run(2);
      check("halt_oob_branch", {31'd0, halted}, 32'd1);
      cycle(1'b0, 1'b0, 1'b1, 32'd0);
      check("halt_resume", {31'd0, halted}, 32'd0);
      run(1);
      check("resume_instr", if_id_instr, mem_word(32'd0));
      run(2);

      // Out-of-range branch while running; branch to last word then halt.
      cycle(1'b0, 1'b0, 1'b1, 32'd200);
      run(1);
      cycle(1'b0, 1'b1, 1'b1, 32'd99);
      run(3);

      // Freeze in HALT keeps HALT.
      cycle(1'b0, 1'b1, 1'b0, '0);

      // Reset during freeze at pc=7.
      cycle(1'b1, 1'b0, 1'b0, '0);
      run(7);
      cycle(1'b0, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b0, '0);
      check("rst_frz_addr", imem_addr, 32'd0);
      check("rst_frz_count", fetch_count, 32'd0);
      run(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
